// File: rtl/vlsu_axi_txn_tracker.sv
// ---------------------------------------------------------------------------
// vlsu_axi_txn_tracker
//
// Outstanding-transaction tracker between the VLSU address generator / store
// unit and the VLSU AXI cut.
//   * Caps in-flight AR and AW bursts independently (AR/AW gated when full).
//   * Holds the W channel until the AW for that burst has been accepted.
//   * Checks R and W beat counts against the issued burst lengths and raises
//     sticky error flags on a mismatch.
//   * Reports occupancy and idle status to the dispatcher.
//
// Parameters
//   MaxRdOutstanding : max in-flight read bursts  (power of two, >= 2)
//   MaxWrOutstanding : max in-flight write bursts (power of two, >= 2)
//   LenWidth         : AXI burst length field width (beats-1)
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   ar_valid_i/ar_len_i/ar_ready_o   AR from address generator
//   ar_valid_o/ar_ready_i            AR to AXI cut
//   aw_valid_i/aw_len_i/aw_ready_o   AW from address generator
//   aw_valid_o/aw_ready_i            AW to AXI cut
//   w_valid_i/w_last_i/w_ready_o     W from store unit
//   w_valid_o/w_ready_i              W to AXI cut
//   r_valid_i/r_ready_i/r_last_i     R channel observed at AXI cut
//   b_valid_i/b_ready_i              B channel observed at AXI cut
//   rd_cnt_o/wr_cnt_o                in-flight read/write bursts
//   rd_idle_o/wr_idle_o              counter == 0
//   rd_err_o/wr_err_o                sticky protocol error flags
//
// Optional build macro VLSU_AXI_TXN_TRACKER_PERF_EN adds 32-bit wrapping
// performance counters perf_rd_bursts_o, perf_wr_bursts_o, perf_ar_stall_o
// and perf_aw_stall_o. Without the macro those ports do not exist.
// ---------------------------------------------------------------------------
module vlsu_axi_txn_tracker #(
    parameter int unsigned MaxRdOutstanding = 8,
    parameter int unsigned MaxWrOutstanding = 8,
    parameter int unsigned LenWidth         = 8
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    // AR
    input  logic                                    ar_valid_i,
    input  logic [LenWidth-1:0]                     ar_len_i,
    output logic                                    ar_ready_o,
    output logic                                    ar_valid_o,
    input  logic                                    ar_ready_i,
    // AW
    input  logic                                    aw_valid_i,
    input  logic [LenWidth-1:0]                     aw_len_i,
    output logic                                    aw_ready_o,
    output logic                                    aw_valid_o,
    input  logic                                    aw_ready_i,
    // W
    input  logic                                    w_valid_i,
    input  logic                                    w_last_i,
    output logic                                    w_ready_o,
    output logic                                    w_valid_o,
    input  logic                                    w_ready_i,
    // R / B observation
    input  logic                                    r_valid_i,
    input  logic                                    r_ready_i,
    input  logic                                    r_last_i,
    input  logic                                    b_valid_i,
    input  logic                                    b_ready_i,
    // Status
    output logic [$clog2(MaxRdOutstanding+1)-1:0]   rd_cnt_o,
    output logic [$clog2(MaxWrOutstanding+1)-1:0]   wr_cnt_o,
    output logic                                    rd_idle_o,
    output logic                                    wr_idle_o,
`ifdef VLSU_AXI_TXN_TRACKER_PERF_EN
    output logic [31:0]                             perf_rd_bursts_o,
    output logic [31:0]                             perf_wr_bursts_o,
    output logic [31:0]                             perf_ar_stall_o,
    output logic [31:0]                             perf_aw_stall_o,
`endif
    output logic                                    rd_err_o,
    output logic                                    wr_err_o
);

    localparam int unsigned RdCntW = $clog2(MaxRdOutstanding + 1);
    localparam int unsigned WrCntW = $clog2(MaxWrOutstanding + 1);
    localparam int unsigned RdPtrW = $clog2(MaxRdOutstanding);
    localparam int unsigned WrPtrW = $clog2(MaxWrOutstanding);
    localparam logic [RdCntW-1:0] RdMax = RdCntW'(MaxRdOutstanding);
    localparam logic [WrCntW-1:0] WrMax = WrCntW'(MaxWrOutstanding);

    // -----------------------------------------------------------------------
    // Read side
    // -----------------------------------------------------------------------
    logic [LenWidth-1:0] rd_len_mem [MaxRdOutstanding];
    logic [RdPtrW-1:0]   rd_wptr_reg;
    logic [RdPtrW-1:0]   rd_rptr_reg;
    logic [RdCntW-1:0]   rd_cnt_reg;
    logic [LenWidth-1:0] rd_beat_reg;
    logic                rd_err_reg;

    logic                rd_full;
    logic                rd_empty;
    logic                ar_fire;
    logic                r_fire;
    logic                rd_pop;
    logic                rd_exp_last;

    // The read-length FIFO occupancy equals rd_cnt, so the counter doubles as
    // the FIFO level.
    assign rd_full     = (rd_cnt_reg == RdMax);
    assign rd_empty    = (rd_cnt_reg == '0);
    assign ar_valid_o  = ar_valid_i & ~rd_full;
    assign ar_ready_o  = ar_ready_i & ~rd_full;
    assign ar_fire     = ar_valid_i & ar_ready_i & ~rd_full;
    assign r_fire      = r_valid_i & r_ready_i;
    assign rd_exp_last = (rd_beat_reg == rd_len_mem[rd_rptr_reg]);
    // A stray last with nothing outstanding is flagged but must not underflow.
    assign rd_pop      = r_fire & r_last_i & ~rd_empty;

    // Length storage carries no reset: validity is defined by the pointers.
    always_ff @(posedge clk_i) begin
        if (ar_fire) begin
            rd_len_mem[rd_wptr_reg] <= ar_len_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_wptr_reg <= '0;
            rd_rptr_reg <= '0;
            rd_cnt_reg  <= '0;
            rd_beat_reg <= '0;
            rd_err_reg  <= 1'b0;
        end else begin
            if (ar_fire) begin
                rd_wptr_reg <= rd_wptr_reg + RdPtrW'(1);
            end
            if (rd_pop) begin
                rd_rptr_reg <= rd_rptr_reg + RdPtrW'(1);
            end
            case ({ar_fire, rd_pop})
                2'b10:   rd_cnt_reg <= rd_cnt_reg + RdCntW'(1);
                2'b01:   rd_cnt_reg <= rd_cnt_reg - RdCntW'(1);
                default: rd_cnt_reg <= rd_cnt_reg;
            endcase
            if (r_fire) begin
                rd_beat_reg <= r_last_i ? '0 : rd_beat_reg + LenWidth'(1);
                if (rd_empty || (r_last_i != rd_exp_last)) begin
                    rd_err_reg <= 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Write side
    // wr_cnt tracks AW accepted minus B received; the W-length FIFO has its
    // own level because W bursts complete before their B arrives.
    // -----------------------------------------------------------------------
    logic [LenWidth-1:0] wf_len_mem [MaxWrOutstanding];
    logic [WrPtrW-1:0]   wf_wptr_reg;
    logic [WrPtrW-1:0]   wf_rptr_reg;
    logic [WrCntW-1:0]   wf_cnt_reg;
    logic [WrCntW-1:0]   wr_cnt_reg;
    logic [LenWidth-1:0] w_beat_reg;
    logic                wr_err_reg;

    logic                wr_full;
    logic                wf_full;
    logic                wf_nonempty;
    logic                aw_fire;
    logic                wf_push;
    logic                w_fire;
    logic                w_pop;
    logic                b_fire;
    logic                b_dec;
    logic                w_exp_last;

    assign wr_full     = (wr_cnt_reg == WrMax);
    assign wf_full     = (wf_cnt_reg == WrMax);
    assign wf_nonempty = (wf_cnt_reg != '0);
    assign aw_valid_o  = aw_valid_i & ~wr_full;
    assign aw_ready_o  = aw_ready_i & ~wr_full;
    assign aw_fire     = aw_valid_i & aw_ready_i & ~wr_full;
    // The FIFO can only be full here after a B arrived ahead of its W data;
    // the length is dropped and the error flag raised instead of overflowing.
    assign wf_push     = aw_fire & ~wf_full;
    // wf_nonempty is registered, so an AW accepted this cycle cannot release
    // W until the next cycle.
    assign w_valid_o   = w_valid_i & wf_nonempty;
    assign w_ready_o   = w_ready_i & wf_nonempty;
    assign w_fire      = w_valid_i & w_ready_i & wf_nonempty;
    assign w_pop       = w_fire & w_last_i;
    assign w_exp_last  = (w_beat_reg == wf_len_mem[wf_rptr_reg]);
    assign b_fire      = b_valid_i & b_ready_i;
    assign b_dec       = b_fire & (wr_cnt_reg != '0);

    always_ff @(posedge clk_i) begin
        if (wf_push) begin
            wf_len_mem[wf_wptr_reg] <= aw_len_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wf_wptr_reg <= '0;
            wf_rptr_reg <= '0;
            wf_cnt_reg  <= '0;
            wr_cnt_reg  <= '0;
            w_beat_reg  <= '0;
            wr_err_reg  <= 1'b0;
        end else begin
            if (wf_push) begin
                wf_wptr_reg <= wf_wptr_reg + WrPtrW'(1);
            end
            if (w_pop) begin
                wf_rptr_reg <= wf_rptr_reg + WrPtrW'(1);
            end
            case ({wf_push, w_pop})
                2'b10:   wf_cnt_reg <= wf_cnt_reg + WrCntW'(1);
                2'b01:   wf_cnt_reg <= wf_cnt_reg - WrCntW'(1);
                default: wf_cnt_reg <= wf_cnt_reg;
            endcase
            case ({aw_fire, b_dec})
                2'b10:   wr_cnt_reg <= wr_cnt_reg + WrCntW'(1);
                2'b01:   wr_cnt_reg <= wr_cnt_reg - WrCntW'(1);
                default: wr_cnt_reg <= wr_cnt_reg;
            endcase
            if (w_fire) begin
                w_beat_reg <= w_last_i ? '0 : w_beat_reg + LenWidth'(1);
            end
            if ((w_fire && (w_last_i != w_exp_last)) ||
                (b_fire && (wr_cnt_reg == '0)) ||
                (aw_fire && wf_full)) begin
                wr_err_reg <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Status outputs
    // -----------------------------------------------------------------------
    assign rd_cnt_o  = rd_cnt_reg;
    assign wr_cnt_o  = wr_cnt_reg;
    assign rd_idle_o = rd_empty;
    assign wr_idle_o = (wr_cnt_reg == '0);
    assign rd_err_o  = rd_err_reg;
    assign wr_err_o  = wr_err_reg;

`ifdef VLSU_AXI_TXN_TRACKER_PERF_EN
    // -----------------------------------------------------------------------
    // Performance counters (free-running, wrap at 2^32)
    // -----------------------------------------------------------------------
    logic [31:0] perf_rd_bursts_reg;
    logic [31:0] perf_wr_bursts_reg;
    logic [31:0] perf_ar_stall_reg;
    logic [31:0] perf_aw_stall_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_rd_bursts_reg <= '0;
            perf_wr_bursts_reg <= '0;
            perf_ar_stall_reg  <= '0;
            perf_aw_stall_reg  <= '0;
        end else begin
            if (ar_fire) begin
                perf_rd_bursts_reg <= perf_rd_bursts_reg + 32'd1;
            end
            if (aw_fire) begin
                perf_wr_bursts_reg <= perf_wr_bursts_reg + 32'd1;
            end
            if (ar_valid_i && rd_full) begin
                perf_ar_stall_reg <= perf_ar_stall_reg + 32'd1;
            end
            if (aw_valid_i && wr_full) begin
                perf_aw_stall_reg <= perf_aw_stall_reg + 32'd1;
            end
        end
    end

    assign perf_rd_bursts_o = perf_rd_bursts_reg;
    assign perf_wr_bursts_o = perf_wr_bursts_reg;
    assign perf_ar_stall_o  = perf_ar_stall_reg;
    assign perf_aw_stall_o  = perf_aw_stall_reg;
`endif

endmodule
